// File: rtl/store_size_ctrl_pkg.sv
// Shared encodings for the store-size controller: store sizes, FSM states and
// the legality rule for size/alignment combinations.
package store_size_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Words must be 4-byte aligned, halves 2-byte aligned; bytes always legal.
  function automatic logic store_legal(input logic [1:0] size, input logic [1:0] lane);
    logic ok;
    case (size)
      SZ_WORD: ok = (lane == 2'b00);
      SZ_HALF: ok = (lane[0] == 1'b0);
      SZ_BYTE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational little-endian lane merge: inserts the store data into the
// word read back from memory according to size and byte offset.
module store_lane_merge
  import store_size_ctrl_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] merged
);

  // Overlay the selected byte/half lane onto the memory word.
  always_comb begin
    merged = rdata;
    case (size)
      SZ_WORD: merged = wdata;
      SZ_HALF: begin
        if (lane[1]) begin
          merged[31:16] = wdata[15:0];
        end else begin
          merged[15:0] = wdata[15:0];
        end
      end
      SZ_BYTE: begin
        case (lane)
          2'b00:   merged[7:0]   = wdata[7:0];
          2'b01:   merged[15:8]  = wdata[7:0];
          2'b10:   merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      default: merged = rdata;
    endcase
  end

endmodule

// File: rtl/store_size_ctrl.sv
// Store controller for sw/sh/sb: word stores write straight through, sub-word
// stores read the target word, merge the new lane(s) and write it back.
module store_size_ctrl
  import store_size_ctrl_pkg::*;
#(
  parameter int READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(READ_WAIT + 1) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_WAIT);

  state_e        state_r;
  logic [1:0]    lane_r;
  logic [1:0]    size_r;
  logic [31:0]   wdata_r;
  logic [CW-1:0] cnt_r;
  logic [31:0]   merged_s;

  store_lane_merge u_merge (
    .lane   (lane_r),
    .size   (size_r),
    .wdata  (wdata_r),
    .rdata  (mem_rdata),
    .merged (merged_s)
  );

  // Request FSM: latch on accept, wait out the read latency, strobe one write, pulse done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      lane_r    <= 2'b00;
      size_r    <= 2'b00;
      wdata_r   <= 32'h0000_0000;
      cnt_r     <= {CW{1'b0}};
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_wr <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            lane_r   <= addr[1:0];
            size_r   <= size;
            wdata_r  <= wdata;
            mem_addr <= {addr[31:2], 2'b00};
            cnt_r    <= {CW{1'b0}};
            busy     <= 1'b1;
            if (!store_legal(size, addr[1:0])) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
              err     <= 1'b1;
            end else if (size == SZ_WORD) begin
              state_r   <= ST_WRITE;
              mem_wdata <= wdata;
              mem_wr    <= 1'b1;
            end else begin
              state_r <= ST_READ;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          // mem_rdata is valid only in the final READ cycle
          if (cnt_r == CNT_LAST) begin
            state_r   <= ST_WRITE;
            mem_wdata <= merged_s;
            mem_wr    <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_WRITE: begin
          state_r <= ST_DONE;
          done    <= 1'b1;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_size_ctrl.sv
// Self-checking bench for store_size_ctrl: scoreboard of expected memory writes
// plus per-scenario latency, error and reset checks.
module tb_store_size_ctrl;
  import store_size_ctrl_pkg::*;

  localparam int RW = 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] mem_model [0:63];
  wr_t         sb_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int wr_count = 0;
  int wr_lat = -1;
  int done_lat = -1;
  logic done_seen = 1'b0;
  logic done_err = 1'b0;

  store_size_ctrl #(.READ_WAIT(RW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  assign mem_rdata = mem_model[mem_addr[7:2]];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop the scoreboard on each write strobe, record done/err timing.
  always @(negedge clk) begin
    wr_t e;
    if (mem_wr) begin
      wr_count++;
      wr_lat = cyc - start_cyc;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr %h data %h required no write", mem_addr, mem_wdata);
      end else begin
        e = sb_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          errors++;
          $display("FAIL write_word got addr %h data %h required addr %h data %h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
    if (err) begin
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL err_without_done got done %b required 1", done);
      end
    end
    if (done) begin
      done_seen = 1'b1;
      done_lat  = cyc - start_cyc;
      done_err  = err;
    end
  end

  function automatic logic [31:0] ref_merge(input logic [1:0] sz, input logic [1:0] lo,
                                            input logic [31:0] wd, input logic [31:0] rd);
    logic [31:0] mask;
    logic [31:0] shw;
    if (sz == SZ_BYTE) begin
      mask = 32'h0000_00FF << (int'(lo) * 8);
      shw  = wd << (int'(lo) * 8);
    end else begin
      mask = 32'h0000_FFFF << (int'(lo[1]) * 16);
      shw  = wd << (int'(lo[1]) * 16);
    end
    return (rd & ~mask) | (shw & mask);
  endfunction

  task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       input logic push, input logic [31:0] exp_data);
    wr_t e;
    @(negedge clk);
    start = 1'b1; size = sz; addr = a; wdata = wd;
    start_cyc = cyc; done_seen = 1'b0; wr_lat = -1; done_lat = -1;
    if (push) begin
      e.addr = {a[31:2], 2'b00};
      e.data = exp_data;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0; size = 2'($urandom); addr = $urandom; wdata = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !done_seen; i++) @(posedge clk);
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL done_timeout got no done required done within 40 cycles");
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got addr %h data %h required 0 0", mem_addr, mem_wdata);
    end
    checks++;
    if ({mem_wr, busy, done, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b required 0000", {mem_wr, busy, done, err});
    end
    reset = 1'b0;
  endtask

  task automatic test_sw();
    issue(SZ_WORD, 32'h40, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL sw_busy got %b required 1", busy); end
    wait_done();
    checks++;
    if (wr_lat !== 1) begin errors++; $display("FAIL sw_wr_lat got %0d required 1", wr_lat); end
    checks++;
    if (done_lat !== 2 || done_err !== 1'b0) begin
      errors++; $display("FAIL sw_done got lat %0d err %b required 2 0", done_lat, done_err);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL sw_idle_busy got %b required 0", busy); end
  endtask

  task automatic test_sb();
    mem_model[16] = 32'h1122_3344;
    issue(SZ_BYTE, 32'h43, 32'h0000_00AB, 1'b1, 32'hAB22_3344);
    wait_done();
    checks++;
    if (wr_lat !== RW + 2) begin errors++; $display("FAIL sb_wr_lat got %0d required %0d", wr_lat, RW + 2); end
    checks++;
    if (done_lat !== RW + 3 || done_err !== 1'b0) begin
      errors++; $display("FAIL sb_done got lat %0d err %b required %0d 0", done_lat, done_err, RW + 3);
    end
  endtask

  task automatic test_sh();
    logic [31:0] a_tab [2] = '{32'h42, 32'h40};
    logic [31:0] d_tab [2] = '{32'hCAFE_3344, 32'h1122_CAFE};
    for (int i = 0; i < 2; i++) begin
      mem_model[16] = 32'h1122_3344;
      issue(SZ_HALF, a_tab[i], 32'h0000_CAFE, 1'b1, d_tab[i]);
      wait_done();
      checks++;
      if (done_lat !== RW + 3 || wr_lat !== RW + 2) begin
        errors++; $display("FAIL sh_latency got wr %0d done %0d required %0d %0d", wr_lat, done_lat, RW + 2, RW + 3);
      end
    end
  endtask

  task automatic test_illegal();
    logic [1:0]  s_tab [3] = '{SZ_ILL, SZ_HALF, SZ_WORD};
    logic [31:0] a_tab [3] = '{32'h40, 32'h41, 32'h42};
    int wr0;
    for (int i = 0; i < 3; i++) begin
      wr0 = wr_count;
      issue(s_tab[i], a_tab[i], 32'h1234_5678, 1'b0, 32'h0);
      wait_done();
      checks++;
      if (done_lat !== 1 || done_err !== 1'b1) begin
        errors++; $display("FAIL illegal_%0d got lat %0d err %b required 1 1", i, done_lat, done_err);
      end
      checks++;
      if (wr_count !== wr0) begin
        errors++; $display("FAIL illegal_%0d_writes got %0d required 0", i, wr_count - wr0);
      end
    end
  endtask

  task automatic test_back_to_back_start();
    wr_t e;
    int wr0;
    wr0 = wr_count;
    mem_model[16] = 32'h1122_3344;
    @(negedge clk);
    start = 1'b1; size = SZ_BYTE; addr = 32'h43; wdata = 32'h0000_00AB;
    start_cyc = cyc; done_seen = 1'b0;
    e.addr = 32'h40; e.data = 32'hAB22_3344;
    sb_q.push_back(e);
    @(posedge clk); #1;
    size = SZ_WORD; addr = 32'h80; wdata = 32'hFFFF_0000;
    for (int i = 0; i < 40 && !done_seen; i++) begin @(negedge clk); #1; end
    start = 1'b0;
    checks++;
    if (!done_seen) begin errors++; $display("FAIL spam_timeout got no done required done"); end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (wr_count - wr0 !== 1) begin errors++; $display("FAIL spam_writes got %0d required 1", wr_count - wr0); end
    checks++;
    if (busy !== 1'b0 || done_lat !== RW + 3) begin
      errors++; $display("FAIL spam_done got busy %b lat %0d required 0 %0d", busy, done_lat, RW + 3);
    end
  endtask

  task automatic test_reset_mid();
    int wr0;
    wr0 = wr_count;
    issue(SZ_BYTE, 32'h41, 32'h0000_0055, 1'b0, 32'h0);
    reset = 1'b1; #1;
    checks++;
    if (mem_wr !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_read got wr %b busy %b required 0 0", mem_wr, busy);
    end
    @(negedge clk); reset = 1'b0;
    issue(SZ_WORD, 32'h44, 32'h1234_5678, 1'b0, 32'h0);
    checks++;
    if (mem_wr !== 1'b1) begin errors++; $display("FAIL rst_write_pre got wr %b required 1", mem_wr); end
    reset = 1'b1; #1;
    checks++;
    if (mem_wr !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_write got wr %b busy %b required 0 0", mem_wr, busy);
    end
    @(negedge clk); reset = 1'b0;
    repeat (RW + 4) @(negedge clk);
    #1;
    checks++;
    if (wr_count !== wr0 || done_seen !== 1'b0) begin
      errors++; $display("FAIL rst_no_complete got writes %0d done %b required 0 0", wr_count - wr0, done_seen);
    end
    issue(SZ_WORD, 32'h48, 32'hA5A5_0F0F, 1'b1, 32'hA5A5_0F0F);
    wait_done();
    checks++;
    if (wr_lat !== 1 || done_lat !== 2) begin
      errors++; $display("FAIL rst_recover got wr %0d done %0d required 1 2", wr_lat, done_lat);
    end
  endtask

  task automatic test_random();
    logic [1:0]  sz;
    logic [1:0]  lo;
    logic [5:0]  idx;
    logic [31:0] wd;
    for (int i = 0; i < 8; i++) begin
      sz  = ($urandom_range(0, 1) == 1) ? SZ_HALF : SZ_BYTE;
      lo  = 2'($urandom_range(0, 3));
      if (sz == SZ_HALF) lo[0] = 1'b0;
      idx = 6'($urandom_range(0, 63));
      wd  = $urandom;
      mem_model[idx] = $urandom;
      issue(sz, {24'h0, idx, lo}, wd, 1'b1, ref_merge(sz, lo, wd, mem_model[idx]));
      wait_done();
      checks++;
      if (sb_q.size() !== 0 || done_err !== 1'b0) begin
        errors++; $display("FAIL rand_%0d got pending %0d err %b required 0 0", i, sb_q.size(), done_err);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_model[i] = 32'h0;
    test_reset();
    test_sw();
    test_sb();
    test_sh();
    test_illegal();
    test_back_to_back_start();
    test_reset_mid();
    test_random();
    checks++;
    if (sb_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
